// File: rtl/facto_host_if.sv
// Command/response and register-bus signals between a client, the factorial
// host and the factorial core's slave port.
interface facto_host_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [63:0]  cmd_operand;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_result;
    logic         rsp_err;
    logic         m_sel;
    logic         m_wr;
    logic [15:0]  m_addr;
    logic [63:0]  m_dout;
    logic [63:0]  m_din;
    logic         irq_in;
    logic         busy;

    // host side: drives the bus and the response
    modport master (
        input  cmd_valid, cmd_operand, rsp_ready, m_din, irq_in,
        output cmd_ready, rsp_valid, rsp_result, rsp_err,
               m_sel, m_wr, m_addr, m_dout, busy
    );

    // environment side: client plus factorial core
    modport slave (
        output cmd_valid, cmd_operand, rsp_ready, m_din, irq_in,
        input  cmd_ready, rsp_valid, rsp_result, rsp_err,
               m_sel, m_wr, m_addr, m_dout, busy
    );
endinterface

// File: rtl/facto_host.sv
// Factorial host: turns one command into the program / start / wait /
// read / clear register sequence on the core's slave port.
module facto_host #(
    parameter logic [15:0] ADDR_OPSTART  = 16'h0000,
    parameter logic [15:0] ADDR_OPCLEAR  = 16'h0008,
    parameter logic [15:0] ADDR_OPDONE   = 16'h0010,
    parameter logic [15:0] ADDR_INTREN   = 16'h0018,
    parameter logic [15:0] ADDR_OPERAND  = 16'h0020,
    parameter logic [15:0] ADDR_RESULT_H = 16'h0028,
    parameter logic [15:0] ADDR_RESULT_L = 16'h0030,
    parameter bit          USE_INTR      = 1'b1,
    parameter int          TIMEOUT       = 4096
) (
    input  logic         clk,
    input  logic         reset,
    facto_host_if.master bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        IDLE, WR_INTR, WR_OPND, WR_START, WAIT, RD_H, RD_L, WR_CLR, WR_CLR0, RESP
    } state_t;

    state_t         state, state_nx;
    logic [63:0]    opnd;
    logic [CW-1:0]  cnt;
    logic           err;
    logic [127:0]   res;
    logic           done_c;
    logic           cnt_last;

    // completion source depends on mode; polling reads opdone while in WAIT
    assign done_c   = USE_INTR ? bus.irq_in : (bus.m_din[1:0] == 2'b11);
    assign cnt_last = (cnt == CW'(TIMEOUT - 1));

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next state and one-cycle bus access decode
    always_comb begin
        state_nx      = state;
        bus.m_sel     = 1'b0;
        bus.m_wr      = 1'b0;
        bus.m_addr    = 16'h0000;
        bus.m_dout    = 64'h0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) state_nx = WR_INTR;
            end
            WR_INTR: begin
                bus.m_sel  = 1'b1;
                bus.m_wr   = 1'b1;
                bus.m_addr = ADDR_INTREN;
                bus.m_dout = 64'(USE_INTR);
                state_nx   = WR_OPND;
            end
            WR_OPND: begin
                bus.m_sel  = 1'b1;
                bus.m_wr   = 1'b1;
                bus.m_addr = ADDR_OPERAND;
                bus.m_dout = opnd;
                state_nx   = WR_START;
            end
            WR_START: begin
                bus.m_sel  = 1'b1;
                bus.m_wr   = 1'b1;
                bus.m_addr = ADDR_OPSTART;
                bus.m_dout = 64'h1;
                state_nx   = WAIT;
            end
            WAIT: begin
                if (!USE_INTR) begin
                    bus.m_sel  = 1'b1;
                    bus.m_addr = ADDR_OPDONE;
                end
                // completion wins over a timeout landing on the same cycle
                if (done_c)        state_nx = RD_H;
                else if (cnt_last) state_nx = WR_CLR;
            end
            RD_H: begin
                bus.m_sel  = 1'b1;
                bus.m_addr = ADDR_RESULT_H;
                state_nx   = RD_L;
            end
            RD_L: begin
                bus.m_sel  = 1'b1;
                bus.m_addr = ADDR_RESULT_L;
                state_nx   = WR_CLR;
            end
            WR_CLR: begin
                bus.m_sel  = 1'b1;
                bus.m_wr   = 1'b1;
                bus.m_addr = ADDR_OPCLEAR;
                bus.m_dout = 64'h1;
                state_nx   = WR_CLR0;
            end
            WR_CLR0: begin
                bus.m_sel  = 1'b1;
                bus.m_wr   = 1'b1;
                bus.m_addr = ADDR_OPCLEAR;
                state_nx   = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // operand latch, wait counter, error flag and result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opnd <= '0;
            cnt  <= '0;
            err  <= 1'b0;
            res  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    opnd <= bus.cmd_operand;
                    err  <= 1'b0;
                    res  <= '0;   // stays zero on the timeout path
                end
                WR_START: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (!done_c && cnt_last) err <= 1'b1;
                end
                RD_H: res[127:64] <= bus.m_din;
                RD_L: res[63:0]   <= bus.m_din;
                default: ;
            endcase
        end
    end

    assign bus.rsp_result = res;
    assign bus.rsp_err    = err;
endmodule

// File: tb/tb_facto_host.sv
// Directed bench: interrupt-mode host (short timeout) and polling-mode host,
// each against a small behavioural factorial core.
module tb_facto_host;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    facto_host_if ia();
    facto_host_if ib();

    facto_host #(.USE_INTR(1'b1), .TIMEOUT(64)) dut_a (.clk(clk), .reset(reset), .bus(ia.master));
    facto_host #(.USE_INTR(1'b0))               dut_b (.clk(clk), .reset(reset), .bus(ib.master));

    int errors = 0;
    int checks = 0;

    function automatic logic [63:0] fact(input logic [63:0] n);
        logic [63:0] r = 64'd1;
        for (longint i = 2; i <= longint'(n); i++) r = r * 64'(i);
        return r;
    endfunction

    // core model A: done 20 cycles after opstart, irq gated by intrEn
    logic [63:0] res_a = '0;
    logic done_a = 1'b0, ien_a = 1'b0, blk_a = 1'b0, force_a = 1'b0;
    int dly_a = 0;
    always @(posedge clk) begin
        if (dly_a > 0) begin
            dly_a <= dly_a - 1;
            if (dly_a == 1) done_a <= 1'b1;
        end
        if (ia.m_sel && ia.m_wr)
            case (ia.m_addr)
                16'h0018: ien_a <= ia.m_dout[0];
                16'h0020: res_a <= fact(ia.m_dout);
                16'h0000: if (ia.m_dout[0]) begin dly_a <= 20; done_a <= 1'b0; end
                16'h0008: if (ia.m_dout[0]) begin dly_a <= 0;  done_a <= 1'b0; end
                default: ;
            endcase
    end
    assign ia.irq_in = (done_a & ien_a & ~blk_a) | force_a;
    assign ia.m_din  = (ia.m_addr == 16'h0030) ? res_a :
                       (ia.m_addr == 16'h0010) ? {62'b0, done_a, done_a} : 64'd0;

    // core model B: done 15 cycles after opstart, polled
    logic [63:0] res_b = '0;
    logic done_b = 1'b0;
    int dly_b = 0;
    always @(posedge clk) begin
        if (dly_b > 0) begin
            dly_b <= dly_b - 1;
            if (dly_b == 1) done_b <= 1'b1;
        end
        if (ib.m_sel && ib.m_wr)
            case (ib.m_addr)
                16'h0020: res_b <= fact(ib.m_dout);
                16'h0000: if (ib.m_dout[0]) begin dly_b <= 15; done_b <= 1'b0; end
                16'h0008: if (ib.m_dout[0]) begin dly_b <= 0;  done_b <= 1'b0; end
                default: ;
            endcase
    end
    assign ib.irq_in = 1'b0;
    assign ib.m_din  = (ib.m_addr == 16'h0030) ? res_b :
                       (ib.m_addr == 16'h0010) ? {62'b0, done_b, done_b} : 64'd0;

    // bus monitors
    logic [79:0] wq_a[$];
    logic [79:0] wq_b[$];
    int wait_a = 0, polls_b = 0, bad = 0;
    always @(posedge clk) begin
        if (ia.m_sel && ia.m_wr) wq_a.push_back({ia.m_addr, ia.m_dout});
        if (ib.m_sel && ib.m_wr) wq_b.push_back({ib.m_addr, ib.m_dout});
        if (ia.busy && !ia.m_sel && !ia.rsp_valid) wait_a++;
        if (ib.m_sel && !ib.m_wr && ib.m_addr == 16'h0010) polls_b++;
        if (ia.m_sel && !ia.m_wr && ia.m_dout != 64'd0) bad++;
        if (ib.m_sel && !ib.m_wr && ib.m_dout != 64'd0) bad++;
        if ((ia.rsp_valid && ia.m_sel) || (ib.rsp_valid && ib.m_sel)) bad++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [63:0] op);
        int n = 0;
        ia.cmd_operand = op;
        ia.cmd_valid = 1'b1;
        while (!ia.cmd_ready && n < 300) begin tick(); n++; end
        tick();
        ia.cmd_valid = 1'b0;
    endtask

    int lat_a;
    task automatic wait_rsp_a(input string tag);
        lat_a = 0;
        while (!ia.rsp_valid && lat_a < 500) begin tick(); lat_a++; end
        chk(tag, 128'(ia.rsp_valid), 128'd1);
    endtask

    task automatic take_a();
        ia.rsp_ready = 1'b1;
        tick();
        ia.rsp_ready = 1'b0;
    endtask

    logic [127:0] r0;
    logic stable;
    int nw;

    initial begin
        ia.cmd_valid = 1'b0; ia.cmd_operand = '0; ia.rsp_ready = 1'b0;
        ib.cmd_valid = 1'b0; ib.cmd_operand = '0; ib.rsp_ready = 1'b0;
        tick(); tick();

        // reset state
        chk("rst_cmd_ready", 128'(ia.cmd_ready), 128'd1);
        chk("rst_busy", 128'(ia.busy), 128'd0);
        chk("rst_m_sel", 128'(ia.m_sel), 128'd0);
        chk("rst_m_wr", 128'(ia.m_wr), 128'd0);
        chk("rst_m_addr", 128'(ia.m_addr), 128'd0);
        chk("rst_m_dout", 128'(ia.m_dout), 128'd0);
        chk("rst_rsp", {125'd0, ia.rsp_valid, ia.rsp_err, |ia.rsp_result}, 128'd0);
        reset = 1'b0;
        tick();

        // interrupt mode, operand 5
        wq_a.delete(); wait_a = 0;
        send_a(64'd5);
        wait_rsp_a("t1_rsp");
        chk("t1_result", ia.rsp_result, 128'd120);
        chk("t1_err", 128'(ia.rsp_err), 128'd0);
        chk("t1_wait", 128'(wait_a), 128'd21);
        chk("t1_nwr", 128'(wq_a.size()), 128'd5);
        chk("t1_w0", 128'(wq_a[0]), 128'({16'h0018, 64'd1}));
        chk("t1_w1", 128'(wq_a[1]), 128'({16'h0020, 64'd5}));
        chk("t1_w2", 128'(wq_a[2]), 128'({16'h0000, 64'd1}));
        chk("t1_w3", 128'(wq_a[3]), 128'({16'h0008, 64'd1}));
        chk("t1_w4", 128'(wq_a[4]), 128'({16'h0008, 64'd0}));

        // response held off, second command ignored
        r0 = ia.rsp_result; stable = 1'b1;
        ia.cmd_operand = 64'd9; ia.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ia.rsp_valid !== 1'b1 || ia.rsp_result !== r0 || ia.cmd_ready !== 1'b0) stable = 1'b0;
        end
        chk("hold_stable", 128'(stable), 128'd1);
        ia.cmd_valid = 1'b0;
        take_a();
        chk("hold_idle", {126'd0, ia.rsp_valid, ia.cmd_ready}, 128'd1);
        tick();
        chk("hold_no_queue", 128'(wq_a.size()), 128'd5);

        // timeout
        wq_a.delete(); wait_a = 0; blk_a = 1'b1;
        send_a(64'd7);
        wait_rsp_a("to_rsp");
        chk("to_err", 128'(ia.rsp_err), 128'd1);
        chk("to_result", ia.rsp_result, 128'd0);
        chk("to_wait", 128'(wait_a), 128'd64);
        chk("to_nwr", 128'(wq_a.size()), 128'd5);
        chk("to_w3", 128'(wq_a[3]), 128'({16'h0008, 64'd1}));
        chk("to_w4", 128'(wq_a[4]), 128'({16'h0008, 64'd0}));
        take_a();
        blk_a = 1'b0;

        // recovery after timeout
        send_a(64'd3);
        wait_rsp_a("rec_rsp");
        chk("rec_result", ia.rsp_result, 128'd6);
        chk("rec_err", 128'(ia.rsp_err), 128'd0);
        take_a();

        // latency with irq already high, operand 1
        force_a = 1'b1;
        send_a(64'd1);
        wait_rsp_a("lat_rsp");
        chk("lat_cycles", 128'(lat_a), 128'd8);
        chk("lat_result", ia.rsp_result, 128'd1);
        take_a();
        force_a = 1'b0;

        // operand 0, back-to-back with cmd_valid held
        ia.cmd_operand = 64'd0; ia.cmd_valid = 1'b1;
        wait_rsp_a("b2b_rsp0");
        chk("b2b_result0", ia.rsp_result, 128'd1);
        take_a();
        chk("b2b_idle", 128'(ia.cmd_ready), 128'd1);
        tick();
        chk("b2b_accept", {111'd0, ia.busy, ia.m_addr}, {111'd0, 1'b1, 16'h0018});
        ia.cmd_valid = 1'b0;
        wait_rsp_a("b2b_rsp1");
        chk("b2b_result1", ia.rsp_result, 128'd1);
        take_a();

        // reset during WAIT
        wq_a.delete();
        send_a(64'd4);
        repeat (5) tick();
        nw = wq_a.size();
        #2 reset = 1'b1;
        #1;
        chk("arst_outs", {122'd0, ia.busy, ia.m_sel, ia.m_wr, ia.rsp_valid, ia.rsp_err, ia.cmd_ready}, 128'd1);
        chk("arst_bus", {ia.m_addr, ia.m_dout, 48'd0}, 128'd0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("arst_no_clr", 128'(wq_a.size()), 128'(nw));
        send_a(64'd4);
        wait_rsp_a("arst_rsp");
        chk("arst_result", ia.rsp_result, 128'd24);
        take_a();

        // polling mode, operand 20
        wq_b.delete(); polls_b = 0;
        ib.cmd_operand = 64'd20; ib.cmd_valid = 1'b1;
        tick();
        ib.cmd_valid = 1'b0;
        for (int n = 0; n < 500 && !ib.rsp_valid; n++) tick();
        chk("poll_rsp", 128'(ib.rsp_valid), 128'd1);
        chk("poll_result", ib.rsp_result, 128'h21C3677C82B40000);
        chk("poll_err", 128'(ib.rsp_err), 128'd0);
        chk("poll_reads", 128'(polls_b), 128'd16);
        chk("poll_nwr", 128'(wq_b.size()), 128'd5);
        chk("poll_w0", 128'(wq_b[0]), 128'({16'h0018, 64'd0}));
        chk("poll_w1", 128'(wq_b[1]), 128'({16'h0020, 64'd20}));
        chk("poll_w2", 128'(wq_b[2]), 128'({16'h0000, 64'd1}));
        chk("poll_w3", 128'(wq_b[3]), 128'({16'h0008, 64'd1}));
        chk("poll_w4", 128'(wq_b[4]), 128'({16'h0008, 64'd0}));
        ib.rsp_ready = 1'b1;
        tick();
        ib.rsp_ready = 1'b0;
        chk("poll_idle", 128'(ib.cmd_ready), 128'd1);

        chk("bus_rules", 128'(bad), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // overall bound in case something stalls outside the bounded waits
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/facto_host.md
Name: facto_host

Overview:
- Bus initiator that drives the factorial core's slave port (sel/wr/addr/data) on behalf of a simple command/response client.
- Takes one operand per command and runs the full sequence:
  - program the core;
  - start it;
  - wait for completion by interrupt or by polling;
  - read the 128-bit result;
  - clear the core.
- Sits between the system-level client and the factorial core, at the other end of that core's register interface.

Parameters:
- ADDR_OPSTART, 16'h0000, opstart register address
- ADDR_OPCLEAR, 16'h0008, opclear register address
- ADDR_OPDONE, 16'h0010, opdone register address
- ADDR_INTREN, 16'h0018, intrEn register address
- ADDR_OPERAND, 16'h0020, operand register address
- ADDR_RESULT_H, 16'h0028, result_h register address
- ADDR_RESULT_L, 16'h0030, result_l register address
- USE_INTR, 1, 1 = wait on irq_in; 0 = poll opdone
- TIMEOUT, 4096, maximum cycles spent in WAIT before aborting

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  host idle, command accepted when valid&ready
- cmd_operand  in  64  factorial operand
- rsp_valid  out  1  result available
- rsp_ready  in  1  client consumes response
- rsp_result  out  128  {result_h, result_l}
- rsp_err  out  1  1 = timeout abort, rsp_result = 0
- m_sel  out  1  slave select (one-cycle accesses)
- m_wr  out  1  1 = write, 0 = read
- m_addr  out  16  register address
- m_dout  out  64  write data
- m_din  in  64  read data, combinational from slave, sampled at the edge ending the access
- irq_in  in  1  core interrupt
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - state = IDLE;
  - m_sel = 0, m_wr = 0, m_addr = 0, m_dout = 0;
  - rsp_valid = 0, rsp_err = 0, rsp_result = 0;
  - cmd_ready = 1, busy = 0;
  - timeout counter = 0.
- Reset asserted mid-sequence: immediate return to IDLE with the values above; no clear write is issued.
- Bus rules:
  - every state except IDLE, WAIT (USE_INTR=1) and RESP drives exactly one access for exactly one cycle;
  - m_sel is low in IDLE, RESP and interrupt-mode WAIT;
  - m_dout is 0 on reads.
- States (one cycle each unless noted):
  - IDLE: cmd_ready=1. On cmd_valid, latch operand, go to WR_INTR.
  - WR_INTR: write ADDR_INTREN, data = {63'b0, USE_INTR}.
  - WR_OPND: write ADDR_OPERAND, data = latched operand.
  - WR_START: write ADDR_OPSTART, data = 64'h1. Clear timeout counter.
  - WAIT, USE_INTR=1: no access. irq_in=1 -> RD_H.
  - WAIT, USE_INTR=0: read ADDR_OPDONE every cycle. m_din[1:0]==2'b11 -> RD_H.
  - WAIT, both modes: counter increments each cycle. Counter reaches TIMEOUT-1 without completion -> set err flag, go to WR_CLR.
  - RD_H: read ADDR_RESULT_H, capture into rsp_result[127:64].
  - RD_L: read ADDR_RESULT_L, capture into rsp_result[63:0].
  - WR_CLR: write ADDR_OPCLEAR, data = 64'h1.
  - WR_CLR0: write ADDR_OPCLEAR, data = 64'h0; next state RESP.
  - RESP: rsp_valid=1, stable until rsp_ready. On rsp_valid & rsp_ready -> IDLE, rsp_valid=0.
- Error path: rsp_err = err flag, rsp_result forced to 0. Err flag clears on the next command accept.
- Completion that coincides with the timeout cycle counts as success.
- Latency, interrupt mode with irq_in already high: cmd accept at cycle 0, writes at cycles 1–3, WAIT at cycle 4, reads at cycles 5–6, clears at cycles 7–8, rsp_valid first high at cycle 9.
- cmd_valid while busy is ignored and not queued.
- rsp_ready while rsp_valid=0 is ignored.
- irq_in outside WAIT is ignored.

Test Plan:
- USE_INTR=1, operand 5, model raises irq_in 20 cycles after opstart -> bus trace INTREN=1, OPERAND=5, OPSTART=1, read H, read L, OPCLEAR=1, then 0; rsp_result=128'd120, rsp_err=0.
- USE_INTR=0, operand 20 -> repeated OPDONE reads until 2'b11; rsp_result=128'h21C3677C82B40000, rsp_err=0, INTREN write data 0.
- irq_in never asserted, TIMEOUT=64 -> exactly 64 WAIT cycles, OPCLEAR 1/0 writes, rsp_err=1, rsp_result=0; next command (operand 3) returns 6 with rsp_err=0.
- rsp_ready held low 10 cycles -> rsp_valid and rsp_result stable, cmd_ready=0, second cmd_valid ignored; rsp_ready pulse -> IDLE the next cycle.
- reset pulsed during WAIT -> all outputs at reset values asynchronously, m_sel=0, no OPCLEAR write, next command completes normally.
- operand 0 and operand 1 -> rsp_result=1 in both cases; back-to-back commands with cmd_valid held high -> second accepted the cycle after the first response handshake.
